// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if: opcode/mem_ready in, multicycle datapath control strobes out
interface mc_control_fsm_if #(
   parameter int OPW = 6,
   parameter int STW = 4
);
   logic [OPW-1:0] op;
   logic           mem_ready;
   logic           PCWrite;
   logic           PCWriteCond;
   logic           IorD;
   logic           MemRead;
   logic           MemWrite;
   logic           IRWrite;
   logic           MemtoReg;
   logic           RegDst;
   logic           RegWrite;
   logic           ALUSrcA;
   logic [1:0]     ALUSrcB;
   logic [1:0]     ALUOp;
   logic [1:0]     PCSource;
   logic           illegal_op;
   logic [STW-1:0] state;
   modport master (
      input  op, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, state
   );
   modport slave (
      output op, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
             RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, state
   );
endinterface

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: Moore main control for the multicycle MIPS datapath (MC_MEM_WAIT_EN adds memory wait states)
module mc_control_fsm #(
   parameter int OPW = 6,
   parameter int STW = 4
) (
   input logic clk,
   input logic rst_n,
   mc_control_fsm_if.master bus
);
   typedef enum logic [STW-1:0] {
      S_RST = 0, S_FETCH = 1, S_DECODE = 2, S_MADR = 3, S_MRD = 4, S_MWB = 5, S_MWR = 6,
      S_REXE = 7, S_RWB = 8, S_BEQ = 9, S_AEXE = 10, S_AWB = 11, S_JMP = 12
   } state_t;
   localparam logic [OPW-1:0] OP_R    = 6'b000000;
   localparam logic [OPW-1:0] OP_LW   = 6'b100011;
   localparam logic [OPW-1:0] OP_SW   = 6'b101011;
   localparam logic [OPW-1:0] OP_BEQ  = 6'b000100;
   localparam logic [OPW-1:0] OP_ADDI = 6'b001000;
   localparam logic [OPW-1:0] OP_J    = 6'b000010;
   state_t state_q, state_d;
   logic   rdy;
`ifdef MC_MEM_WAIT_EN
   assign rdy = bus.mem_ready;
`else
   // mem_ready has no effect: every memory access completes in one cycle
   assign rdy = bus.mem_ready | 1'b1;
`endif
   // state register; reset forces RST so all Moore outputs drop immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_RST;
      else        state_q <= state_d;
   end
   // next state and per-state control outputs
   always_comb begin
      state_d         = S_FETCH;
      bus.PCWrite     = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.IorD        = 1'b0;
      bus.MemRead     = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.MemtoReg    = 1'b0;
      bus.RegDst      = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.ALUSrcA     = 1'b0;
      bus.ALUSrcB     = 2'b00;
      bus.ALUOp       = 2'b00;
      bus.PCSource    = 2'b00;
      bus.illegal_op  = 1'b0;
      case (state_q)
         S_FETCH: begin
            bus.MemRead = 1'b1;
            bus.ALUSrcB = 2'b01;
            bus.IRWrite = rdy;
            bus.PCWrite = rdy;
            state_d     = rdy ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            bus.ALUSrcB = 2'b11;
            case (bus.op)
               OP_R:         state_d = S_REXE;
               OP_LW, OP_SW: state_d = S_MADR;
               OP_BEQ:       state_d = S_BEQ;
               OP_ADDI:      state_d = S_AEXE;
               OP_J:         state_d = S_JMP;
               default:      bus.illegal_op = 1'b1;
            endcase
         end
         S_MADR: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
            state_d     = (bus.op == OP_LW) ? S_MRD : S_MWR;
         end
         S_MRD: begin
            bus.MemRead = 1'b1;
            bus.IorD    = 1'b1;
            state_d     = rdy ? S_MWB : S_MRD;
         end
         S_MWB: begin
            bus.RegWrite = 1'b1;
            bus.MemtoReg = 1'b1;
         end
         S_MWR: begin
            bus.MemWrite = 1'b1;
            bus.IorD     = 1'b1;
            state_d      = rdy ? S_FETCH : S_MWR;
         end
         S_REXE: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUOp   = 2'b10;
            state_d     = S_RWB;
         end
         S_RWB: begin
            bus.RegWrite = 1'b1;
            bus.RegDst   = 1'b1;
         end
         S_BEQ: begin
            bus.ALUSrcA     = 1'b1;
            bus.ALUOp       = 2'b01;
            bus.PCWriteCond = 1'b1;
            bus.PCSource    = 2'b01;
         end
         S_AEXE: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = 2'b10;
            state_d     = S_AWB;
         end
         S_AWB: bus.RegWrite = 1'b1;
         S_JMP: begin
            bus.PCWrite  = 1'b1;
            bus.PCSource = 2'b10;
         end
         default: state_d = S_FETCH;
      endcase
   end
   assign bus.state = state_q;
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: per-instruction control-word sequences checked against the FSM (honours MC_MEM_WAIT_EN)
module tb_mc_control_fsm;
   logic clk = 1'b0;
   logic rst_n;
   int   nchk = 0;
   int   nfail = 0;
   mc_control_fsm_if #(.OPW(6), .STW(4)) bus ();
   mc_control_fsm #(.OPW(6), .STW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   // control word: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite ALUSrcA ALUSrcB ALUOp PCSource
   function automatic logic [15:0] obs_cw();
      return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
              bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource};
   endfunction
   function automatic logic [15:0] cw(input string n);
      case (n)
         "F":    return 16'b1001_0100_0001_0000;
         "FW":   return 16'b0001_0000_0001_0000;
         "D":    return 16'b0000_0000_0011_0000;
         "MADR": return 16'b0000_0000_0110_0000;
         "MRD":  return 16'b0011_0000_0000_0000;
         "MWB":  return 16'b0000_0010_1000_0000;
         "MWR":  return 16'b0010_1000_0000_0000;
         "REXE": return 16'b0000_0000_0100_1000;
         "RWB":  return 16'b0000_0001_1000_0000;
         "BEQ":  return 16'b0100_0000_0100_0101;
         "AEXE": return 16'b0000_0000_0110_0000;
         "AWB":  return 16'b0000_0000_1000_0000;
         "JMP":  return 16'b1000_0000_0000_0010;
         default: return 16'hxxxx;
      endcase
   endfunction
   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      nchk++;
      assert (o === e) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, "_cw"}, {16'h0, obs_cw()}, 32'h0);
      chk({tag, "_ill"}, {31'h0, bus.illegal_op}, 32'h0);
      chk({tag, "_state"}, {28'h0, bus.state}, 32'h0);
   endtask
   // one cycle: drive mem_ready, check the Moore outputs, advance to just after the next edge
   task automatic step(input string n, input logic rdy, input logic ill);
      bus.mem_ready = rdy;
      #1;
      chk({"cw_", n}, {16'h0, obs_cw()}, {16'h0, cw(n)});
      chk({"ill_", n}, {31'h0, bus.illegal_op}, {31'h0, ill});
      chk("excl_rw_mw", {31'h0, bus.RegWrite & bus.MemWrite}, 32'h0);
      chk("excl_pc", {31'h0, bus.PCWrite & bus.PCWriteCond}, 32'h0);
      @(posedge clk);
      #1;
   endtask
   task automatic mem_step(input string n);
`ifdef MC_MEM_WAIT_EN
      int w = $urandom_range(0, 3);
      repeat (w) step((n == "F") ? "FW" : n, 1'b0, 1'b0);
      step(n, 1'b1, 1'b0);
`else
      step(n, 1'($urandom % 2), 1'b0);
`endif
   endtask
   // each opcode expands to its fixed microstep list; anything unrecognised is fetch+decode only
   task automatic run_instr(input logic [5:0] op);
      string q[$];
      logic  ill = 1'b0;
      case (op)
         6'b100011: q = '{"F", "D", "MADR", "MRD", "MWB"};
         6'b101011: q = '{"F", "D", "MADR", "MWR"};
         6'b000000: q = '{"F", "D", "REXE", "RWB"};
         6'b001000: q = '{"F", "D", "AEXE", "AWB"};
         6'b000100: q = '{"F", "D", "BEQ"};
         6'b000010: q = '{"F", "D", "JMP"};
         default: begin q = '{"F", "D"}; ill = 1'b1; end
      endcase
      bus.op = op;
      foreach (q[i]) begin
         if (q[i] == "F" || q[i] == "MRD" || q[i] == "MWR") mem_step(q[i]);
         else step(q[i], 1'($urandom % 2), (q[i] == "D") ? ill : 1'b0);
      end
   endtask
   initial begin
      logic [5:0] legal [6];
      int n;
      legal = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
      rst_n = 1'b0;
      bus.op = 6'b0;
      bus.mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_reset("rst_release");
      @(posedge clk);
      #1;
      run_instr(6'b100011);
      run_instr(6'b000000);
      run_instr(6'b101011);
      run_instr(6'b000100);
      run_instr(6'b000010);
      run_instr(6'b001000);
      run_instr(6'b111111);
      // lw latency with mem_ready low for the first three cycles of MRD
      bus.op = 6'b100011;
      n = 0;
      do begin
         bus.mem_ready = (n >= 3 && n <= 5) ? 1'b0 : 1'b1;
         @(posedge clk);
         #1;
         n++;
      end while (!bus.IRWrite && n < 20);
`ifdef MC_MEM_WAIT_EN
      chk("lw_cycles", n, 8);
`else
      chk("lw_cycles", n, 5);
`endif
      // reset asserted during MWB must kill RegWrite at once
      step("F", 1'b1, 1'b0);
      step("D", 1'b1, 1'b0);
      step("MADR", 1'b1, 1'b0);
      step("MRD", 1'b1, 1'b0);
      chk("mwb_regwrite", {31'h0, bus.RegWrite}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk_reset("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 200; i++)
         run_instr(($urandom % 2) ? legal[$urandom % 6] : 6'($urandom % 64));
      step("F", 1'b1, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
      $finish;
   end
endmodule
